// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// fetch_ctrl_if : control/handshake bundle between the lookup stage and fetch_ctrl
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            Stall;
  logic            Halt;
  logic            Jump;
  logic            BranchEn;
  logic            Taken;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] PC;
  logic [1:0]      ProgIdx;
  logic            Running;
  logic            Done;
  logic            AllDone;

  modport master (
    output Start, Stall, Halt, Jump, BranchEn, Taken, Target,
    input  PC, ProgIdx, Running, Done, AllDone
  );

  modport slave (
    input  Start, Stall, Halt, Jump, BranchEn, Taken, Target,
    output PC, ProgIdx, Running, Done, AllDone
  );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : program counter and program sequencer driving instruction memory
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter int PC_W      = 10,
  parameter int NUM_PROGS = 3,
  parameter int REL_MODE  = 0
) (
  input  wire logic   CLK,
  input  wire logic   Reset_n,
  fetch_ctrl_if.slave bus
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_RUN      = 2'd1;
  localparam logic [1:0] c_DONE     = 2'd2;
  localparam logic [1:0] c_LAST_IDX = 2'(NUM_PROGS - 1);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      idx_q, idx_d;
  logic            alldone_q, alldone_d;
  logic            running_q, running_d;
  logic            done_q, done_d;

  logic [PC_W-1:0] w_br_pc;
  logic [PC_W-1:0] w_pc_inc;

  assign w_pc_inc = pc_q + PC_W'(1);

  // Target and PC share a width, so a plain modular add is the sign-extended add.
  generate
    if (REL_MODE != 0) begin : g_rel
      assign w_br_pc = pc_q + bus.Target;
    end else begin : g_abs
      assign w_br_pc = bus.Target;
    end
  endgenerate

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= c_IDLE;
      pc_q      <= '0;
      idx_q     <= '0;
      alldone_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      alldone_q <= alldone_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    alldone_d = alldone_q;
    case (state_q)
      c_IDLE: begin
        if (bus.Start && !alldone_q) begin
          state_d = c_RUN;
        end
      end
      c_RUN: begin
        if (!bus.Stall) begin
          if (bus.Halt) begin
            // Programs are packed back-to-back: next one begins right after Halt.
            state_d = c_DONE;
            pc_d    = w_pc_inc;
            if (idx_q == c_LAST_IDX) begin
              idx_d     = '0;
              alldone_d = 1'b1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else if (bus.Jump || (bus.BranchEn && bus.Taken)) begin
            pc_d = w_br_pc;
          end else begin
            pc_d = w_pc_inc;
          end
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_comb begin
    running_d = (state_d == c_RUN);
    done_d    = (state_d == c_DONE);
  end

  assign bus.PC      = pc_q;
  assign bus.ProgIdx = idx_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;
  assign bus.AllDone = alldone_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : directed scoreboard bench for absolute and relative fetch_ctrl
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  localparam logic [5:0] c_NONE  = 6'b000000;
  localparam logic [5:0] c_START = 6'b100000;
  localparam logic [5:0] c_STALL = 6'b010000;
  localparam logic [5:0] c_HALT  = 6'b001000;
  localparam logic [5:0] c_JMP   = 6'b000100;
  localparam logic [5:0] c_BR    = 6'b000010;
  localparam logic [5:0] c_TKN   = 6'b000001;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_checks;

  logic [14:0] sb[$];

  fetch_ctrl_if #(.PC_W(10)) ia();
  fetch_ctrl_if #(.PC_W(10)) ib();

  fetch_ctrl #(.PC_W(10), .NUM_PROGS(3), .REL_MODE(0)) u_abs (
    .CLK(clk), .Reset_n(rst_n), .bus(ia)
  );

  fetch_ctrl #(.PC_W(10), .NUM_PROGS(3), .REL_MODE(1)) u_rel (
    .CLK(clk), .Reset_n(rst_n), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] obs(input bit sel);
    if (sel) return {ib.PC, ib.ProgIdx, ib.Running, ib.Done, ib.AllDone};
    return {ia.PC, ia.ProgIdx, ia.Running, ia.Done, ia.AllDone};
  endfunction

  task automatic drive(input bit sel, input logic [5:0] ctl, input logic [9:0] tgt);
    if (sel) begin
      {ib.Start, ib.Stall, ib.Halt, ib.Jump, ib.BranchEn, ib.Taken} = ctl;
      ib.Target = tgt;
    end else begin
      {ia.Start, ia.Stall, ia.Halt, ia.Jump, ia.BranchEn, ia.Taken} = ctl;
      ia.Target = tgt;
    end
  endtask

  task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed pc/idx/run/done/all=%h/%0d/%b/%b/%b expected=%h/%0d/%b/%b/%b",
             tag, o[14:5], o[4:3], o[2], o[1], o[0], e[14:5], e[4:3], e[2], e[1], e[0]);
    end
  endtask

  // One clock: drive controls, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input bit sel, input logic [5:0] ctl,
                      input logic [9:0] tgt, input logic [9:0] epc, input logic [1:0] eidx,
                      input logic er, input logic ed, input logic ea);
    drive(sel, ctl, tgt);
    sb.push_back({epc, eidx, er, ed, ea});
    @(posedge clk);
    #1;
    chk(tag, obs(sel), sb.pop_front());
    drive(sel, c_NONE, 10'h000);
  endtask

  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    chk({tag, "_a"}, obs(1'b0), 15'h0000);
    chk({tag, "_b"}, obs(1'b1), 15'h0000);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    rst_n    = 1'b0;
    drive(1'b0, c_NONE, 10'h000);
    drive(1'b1, c_NONE, 10'h000);
    #2;
    chk("reset_abs", obs(1'b0), 15'h0000);
    chk("reset_rel", obs(1'b1), 15'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("start",      0, c_START,        10'h000, 10'h000, 2'd0, 1, 0, 0);
    step("seq1",       0, c_NONE,         10'h000, 10'h001, 2'd0, 1, 0, 0);
    step("seq2",       0, c_NONE,         10'h000, 10'h002, 2'd0, 1, 0, 0);
    step("seq3",       0, c_NONE,         10'h000, 10'h003, 2'd0, 1, 0, 0);
    step("seq4",       0, c_NONE,         10'h000, 10'h004, 2'd0, 1, 0, 0);
    step("seq5",       0, c_NONE,         10'h000, 10'h005, 2'd0, 1, 0, 0);
    step("halt_wins",  0, c_JMP | c_HALT, 10'h120, 10'h006, 2'd1, 0, 1, 0);
    step("done_idle",  0, c_NONE,         10'h120, 10'h006, 2'd1, 0, 0, 0);
    step("start2",     0, c_START,        10'h000, 10'h006, 2'd1, 1, 0, 0);
    step("jump_abs",   0, c_JMP,          10'h120, 10'h120, 2'd1, 1, 0, 0);
    step("br_tkn_abs", 0, c_BR | c_TKN,   10'h007, 10'h007, 2'd1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall_halt", 0, c_STALL | c_HALT | c_JMP, 10'h100, 10'h007, 2'd1, 1, 0, 0);
    step("halt2",      0, c_HALT,         10'h000, 10'h008, 2'd2, 0, 1, 0);
    step("start_done", 0, c_START,        10'h000, 10'h008, 2'd2, 0, 0, 0);
    step("start3",     0, c_START,        10'h000, 10'h008, 2'd2, 1, 0, 0);
    step("start_run",  0, c_START,        10'h000, 10'h009, 2'd2, 1, 0, 0);
    step("br_ntkn",    0, c_BR,           10'h3FC, 10'h00A, 2'd2, 1, 0, 0);
    step("halt_last",  0, c_HALT,         10'h000, 10'h00B, 2'd0, 0, 1, 1);
    step("after_all",  0, c_START,        10'h000, 10'h00B, 2'd0, 0, 0, 1);
    step("start_lock", 0, c_START,        10'h000, 10'h00B, 2'd0, 0, 0, 1);

    async_reset("rst_idle");
    step("start4",     0, c_START,        10'h000, 10'h000, 2'd0, 1, 0, 0);
    step("jump_055",   0, c_JMP,          10'h055, 10'h055, 2'd0, 1, 0, 0);
    async_reset("rst_midrun");
    step("post_rst",   0, c_NONE,         10'h000, 10'h000, 2'd0, 0, 0, 0);

    step("r_start",    1, c_START,        10'h000, 10'h000, 2'd0, 1, 0, 0);
    step("r_jump",     1, c_JMP,          10'h010, 10'h010, 2'd0, 1, 0, 0);
    step("r_br_back",  1, c_BR | c_TKN,   10'h3FC, 10'h00C, 2'd0, 1, 0, 0);
    step("r_jump_fwd", 1, c_JMP,          10'h004, 10'h010, 2'd0, 1, 0, 0);
    step("r_br_ntkn",  1, c_BR,           10'h3FC, 10'h011, 2'd0, 1, 0, 0);
    step("r_to_3ff",   1, c_JMP,          10'h3EE, 10'h3FF, 2'd0, 1, 0, 0);
    step("r_wrap",     1, c_NONE,         10'h000, 10'h000, 2'd0, 1, 0, 0);
    step("r_underflw", 1, c_JMP,          10'h3FF, 10'h3FF, 2'd0, 1, 0, 0);
    step("r_halt",     1, c_HALT,         10'h000, 10'h000, 2'd1, 0, 1, 0);
    step("r_idle",     1, c_NONE,         10'h000, 10'h000, 2'd1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
